// File: rtl/rf_write_arbiter.sv
// rtl/rf_write_arbiter.sv - round-robin arbiter for the shared 16-entry register-file write port.
// Optional: RF_ZERO_REG_PROTECT_EN suppresses writes to register 0 (still acked, still rotates).
module rf_write_arbiter #(
  parameter  int NREQ = 4,
  parameter  int DW   = 8,
  localparam int PW   = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [4*NREQ-1:0] req_addr,
  input  logic [DW*NREQ-1:0] req_data,
  input  logic              rf_stall,
  output logic [NREQ-1:0]   ack,
  output logic              wr_en,
  output logic [3:0]        wr_addr,
  output logic [DW-1:0]     wr_data,
  output logic [15:0]       wr_sel,
  output logic [PW-1:0]     rr_ptr
);

  logic [NREQ-1:0] ack_q, ack_d;
  logic            wr_en_q, wr_en_d;
  logic [3:0]      wr_addr_q, wr_addr_d;
  logic [DW-1:0]   wr_data_q, wr_data_d;
  logic [15:0]     wr_sel_q, wr_sel_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;

  logic [NREQ-1:0] elig;
  logic            found;
  logic            grant;
  logic [PW-1:0]   win;
  logic [3:0]      win_addr;
  logic [DW-1:0]   win_data;
  int              idx;
  int              nxt;

  // Winner search: first eligible index starting at rr_ptr, wrapping modulo NREQ.
  always_comb begin
    elig  = req & ~ack_q;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && elig[idx]) begin
        found = 1'b1;
        win   = PW'(idx);
      end
    end
  end

  always_comb begin
    grant    = found && !rf_stall;
    win_addr = req_addr[4*int'(win) +: 4];
    win_data = req_data[DW*int'(win) +: DW];
    nxt      = int'(win) + 1;
    if (nxt == NREQ) nxt = 0;

    ack_d     = '0;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_sel_d  = '0;
    rr_ptr_d  = rr_ptr_q;

    if (grant) begin
      ack_d[win] = 1'b1;
      wr_addr_d  = win_addr;
      wr_data_d  = win_data;
      rr_ptr_d   = PW'(nxt);
`ifdef RF_ZERO_REG_PROTECT_EN
      wr_en_d    = (win_addr != 4'd0);
`else
      wr_en_d    = 1'b1;
`endif
    end
    if (wr_en_d) wr_sel_d[win_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_sel_q  <= '0;
      rr_ptr_q  <= '0;
    end else begin
      ack_q     <= ack_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_sel_q  <= wr_sel_d;
      rr_ptr_q  <= rr_ptr_d;
    end
  end

  assign ack     = ack_q;
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign wr_sel  = wr_sel_q;
  assign rr_ptr  = rr_ptr_q;

endmodule
